// File: rtl/uart_loader_pkg.sv
// Shared definitions for the UART program loader: FSM encoding and frame marker default.
package uart_loader_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ADDR,
    ST_LEN,
    ST_DATA,
    ST_CSUM
  } state_t;

  localparam logic [7:0] SYNC_BYTE_DEFAULT = 8'hA5;

endpackage

// File: rtl/rx_edge_detect.sv
// Turns a level-style UART done flag into a single-cycle byte-valid pulse.
module rx_edge_detect (
  input  logic clk,
  input  logic rst,
  input  logic done,
  output logic pulse
);

  logic done_q;

  always_ff @(posedge clk) begin
    if (rst) done_q <= 1'b0;
    else     done_q <= done;
  end

  assign pulse = done & ~done_q;

endmodule

// File: rtl/uart_loader_ctrl.sv
// Parses SYNC/ADDR/LEN/DATA/CSUM frames from a UART and writes the payload into program memory.
module uart_loader_ctrl
  import uart_loader_pkg::*;
#(
  parameter logic [7:0]  SYNC_BYTE   = SYNC_BYTE_DEFAULT,
  parameter int unsigned TIMEOUT_CYC = 1_000_000
) (
  input  logic       sys_clk,
  input  logic       rst,
  input  logic       uart_rx_done,
  input  logic [7:0] uart_rx_data,
  output logic       mem_we,
  output logic [7:0] mem_addr,
  output logic [7:0] mem_wdata,
  output logic       cpu_hold,
  output logic       load_ok,
  output logic       load_err
);

  localparam int unsigned TMO_W = $clog2(TIMEOUT_CYC + 1);

  state_t           state, state_next;
  logic             byte_vld;
  logic             timeout;
  logic [TMO_W-1:0] tmo_cnt;
  logic [8:0]       remain;
  logic [7:0]       ptr;
  logic [7:0]       sum;
  logic             do_write, do_ok, do_err, set_hold;

  rx_edge_detect u_rx_edge (
    .clk   (sys_clk),
    .rst   (rst),
    .done  (uart_rx_done),
    .pulse (byte_vld)
  );

  // A byte arriving on the expiry cycle wins over the timeout.
  assign timeout = (state != ST_IDLE) && !byte_vld &&
                   (tmo_cnt == TMO_W'(TIMEOUT_CYC - 1));

  always_ff @(posedge sys_clk) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    if (timeout) begin
      state_next = ST_IDLE;
    end else if (byte_vld) begin
      case (state)
        ST_IDLE: if (uart_rx_data == SYNC_BYTE) state_next = ST_ADDR;
        ST_ADDR: state_next = ST_LEN;
        ST_LEN:  state_next = ST_DATA;
        ST_DATA: if (remain == 9'd1) state_next = ST_CSUM;
        ST_CSUM: state_next = ST_IDLE;
        default: state_next = ST_IDLE;
      endcase
    end
  end

  always_comb begin
    do_write = byte_vld && (state == ST_DATA);
    do_ok    = byte_vld && (state == ST_CSUM) && (uart_rx_data == sum);
    do_err   = timeout || (byte_vld && (state == ST_CSUM) && (uart_rx_data != sum));
    set_hold = byte_vld && (state == ST_IDLE) && (uart_rx_data == SYNC_BYTE);
  end

  always_ff @(posedge sys_clk) begin
    if (rst) begin
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      cpu_hold  <= 1'b0;
      load_ok   <= 1'b0;
      load_err  <= 1'b0;
      tmo_cnt   <= '0;
      remain    <= '0;
      ptr       <= '0;
      sum       <= '0;
    end else begin
      mem_we   <= do_write;
      load_ok  <= do_ok;
      load_err <= do_err;
      if (do_write) begin
        mem_addr  <= ptr;
        mem_wdata <= uart_rx_data;
      end
      if (set_hold)   cpu_hold <= 1'b1;
      else if (do_ok) cpu_hold <= 1'b0;
      if (state == ST_IDLE || byte_vld) tmo_cnt <= '0;
      else                              tmo_cnt <= tmo_cnt + 1'b1;
      if (byte_vld) begin
        case (state)
          ST_IDLE: sum <= '0;
          ST_ADDR: begin
            ptr <= uart_rx_data;
            sum <= uart_rx_data;
          end
          ST_LEN: begin
            remain <= (uart_rx_data == 8'h00) ? 9'd256 : {1'b0, uart_rx_data};
            sum    <= sum + uart_rx_data;
          end
          ST_DATA: begin
            remain <= remain - 9'd1;
            ptr    <= ptr + 8'd1;
            sum    <= sum + uart_rx_data;
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_uart_loader_ctrl.sv
// Scoreboard bench: one loader with the default timeout, one with a short timeout.
module tb_uart_loader_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       done_a, done_b;
  logic [7:0] data_a, data_b;
  logic       we_a, hold_a, ok_a, err_a;
  logic [7:0] addr_a, wdata_a;
  logic       we_b, hold_b, ok_b, err_b;
  logic [7:0] addr_b, wdata_b;

  int checks = 0;
  int errors = 0;

  logic [15:0] wr_q_a[$], wr_q_b[$];
  logic [1:0]  res_q_a[$], res_q_b[$];
  logic [7:0]  fdata[$];

  always #5 clk = ~clk;

  uart_loader_ctrl dut_a (
    .sys_clk(clk), .rst(rst), .uart_rx_done(done_a), .uart_rx_data(data_a),
    .mem_we(we_a), .mem_addr(addr_a), .mem_wdata(wdata_a),
    .cpu_hold(hold_a), .load_ok(ok_a), .load_err(err_a)
  );

  uart_loader_ctrl #(.TIMEOUT_CYC(100)) dut_b (
    .sys_clk(clk), .rst(rst), .uart_rx_done(done_b), .uart_rx_data(data_b),
    .mem_we(we_b), .mem_addr(addr_b), .mem_wdata(wdata_b),
    .cpu_hold(hold_b), .load_ok(ok_b), .load_err(err_b)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Result codes are {load_err, load_ok}.
  always @(negedge clk) begin
    if (we_a) begin
      if (wr_q_a.size() == 0) check_eq("a_unexp_wr", {addr_a, wdata_a}, 32'hFFFF_FFFF);
      else check_eq("a_wr", {addr_a, wdata_a}, wr_q_a.pop_front());
    end
    if (ok_a || err_a) begin
      if (res_q_a.size() == 0) check_eq("a_unexp_res", {err_a, ok_a}, 0);
      else check_eq("a_res", {err_a, ok_a}, res_q_a.pop_front());
    end
  end

  always @(negedge clk) begin
    if (we_b) begin
      if (wr_q_b.size() == 0) check_eq("b_unexp_wr", {addr_b, wdata_b}, 32'hFFFF_FFFF);
      else check_eq("b_wr", {addr_b, wdata_b}, wr_q_b.pop_front());
    end
    if (ok_b || err_b) begin
      if (res_q_b.size() == 0) check_eq("b_unexp_res", {err_b, ok_b}, 0);
      else check_eq("b_res", {err_b, ok_b}, res_q_b.pop_front());
    end
  end

  task automatic send_byte(input bit inst, input logic [7:0] b, input int unsigned hold);
    @(posedge clk); #1;
    if (inst) begin data_b = b; done_b = 1'b1; end
    else      begin data_a = b; done_a = 1'b1; end
    repeat (hold) @(posedge clk);
    #1;
    if (inst) done_b = 1'b0;
    else      done_a = 1'b0;
    @(posedge clk); #1;
  endtask

  // Checksum is the plain mod-256 sum of ADDR, LEN and the data bytes.
  task automatic send_frame(input bit inst, input logic [7:0] addr, input bit bad, input int unsigned hold);
    logic [7:0] len, sum, csum;
    len = 8'(fdata.size());
    sum = addr + len;
    foreach (fdata[i]) sum = sum + fdata[i];
    csum = bad ? sum + 8'h0F : sum;
    foreach (fdata[i]) begin
      if (inst) wr_q_b.push_back({addr + 8'(i), fdata[i]});
      else      wr_q_a.push_back({addr + 8'(i), fdata[i]});
    end
    if (inst) res_q_b.push_back(bad ? 2'b10 : 2'b01);
    else      res_q_a.push_back(bad ? 2'b10 : 2'b01);
    send_byte(inst, 8'hA5, hold);
    check_eq("hold_mid", inst ? hold_b : hold_a, 1);
    send_byte(inst, addr, hold);
    send_byte(inst, len, hold);
    foreach (fdata[i]) send_byte(inst, fdata[i], hold);
    send_byte(inst, csum, hold);
    repeat (3) @(posedge clk);
    #1;
    check_eq("hold_after", inst ? hold_b : hold_a, bad ? 1 : 0);
  endtask

  initial begin
    #500_000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    int  lat;
    bit  seen;
    rst = 1'b1;
    done_a = 1'b0; done_b = 1'b0;
    data_a = '0;   data_b = '0;
    repeat (3) @(posedge clk);
    #1;
    check_eq("rst_a", {we_a, hold_a, ok_a, err_a, addr_a, wdata_a}, 0);
    check_eq("rst_b", {we_b, hold_b, ok_b, err_b, addr_b, wdata_b}, 0);
    rst = 1'b0;

    // basic frame, then bad checksum followed by recovery
    fdata = '{8'h11, 8'h22, 8'h33};
    send_frame(1'b0, 8'h10, 1'b0, 1);
    send_frame(1'b0, 8'h10, 1'b1, 1);
    send_frame(1'b0, 8'h10, 1'b0, 1);

    // address wraps past 8'hFF
    fdata = '{8'h01, 8'h02, 8'h03};
    send_frame(1'b0, 8'hFE, 1'b0, 1);

    // long-held done flag with stray bytes ahead of the frame
    send_byte(1'b0, 8'h00, 500);
    send_byte(1'b0, 8'h55, 500);
    fdata = '{8'h11, 8'h22, 8'h33};
    send_frame(1'b0, 8'h10, 1'b0, 500);

    // LEN = 0 carries 256 data bytes
    fdata = {};
    for (int unsigned i = 0; i < 256; i++) fdata.push_back(8'(i * 7 + 3));
    send_frame(1'b0, 8'h80, 1'b0, 1);

    // reset in the middle of a frame
    wr_q_a.push_back({8'h10, 8'h11});
    wr_q_a.push_back({8'h11, 8'h22});
    send_byte(1'b0, 8'hA5, 1);
    send_byte(1'b0, 8'h10, 1);
    send_byte(1'b0, 8'h03, 1);
    send_byte(1'b0, 8'h11, 1);
    send_byte(1'b0, 8'h22, 1);
    rst = 1'b1;
    @(posedge clk); #1;
    check_eq("rst_mid", {we_a, hold_a, ok_a, err_a, addr_a, wdata_a}, 0);
    rst = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    fdata = '{8'h11, 8'h22, 8'h33};
    send_frame(1'b0, 8'h10, 1'b0, 1);

    // inter-byte timeout on the short-timeout instance
    res_q_b.push_back(2'b10);
    send_byte(1'b1, 8'hA5, 1);
    send_byte(1'b1, 8'h10, 1);
    seen = 1'b0;
    lat  = 0;
    for (int i = 0; i < 150 && !seen; i++) begin
      @(negedge clk);
      if (err_b) seen = 1'b1;
      else       lat++;
    end
    check_eq("tmo_seen", seen, 1);
    check_eq("tmo_lat_window", (lat >= 95 && lat <= 105), 1);
    repeat (3) @(posedge clk);
    #1;
    check_eq("tmo_hold", hold_b, 1);
    send_frame(1'b1, 8'h40, 1'b0, 1);

    repeat (5) @(posedge clk);
    #1;
    check_eq("a_wr_left", wr_q_a.size(), 0);
    check_eq("a_res_left", res_q_a.size(), 0);
    check_eq("b_wr_left", wr_q_b.size(), 0);
    check_eq("b_res_left", res_q_b.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
